age_ordered_issue_select: RTL and testbench

- Parametrised successor to the single-pick, lowest-index dispatch selector.
- Tracks the relative age of issue-queue entries with an age matrix.
- Each cycle, selects up to ISSUE_WIDTH ready entries, oldest first (or lowest-index in legacy mode), and registers them into per-port dispatch slots with valid/ready handshakes toward the functional units.
- Sits between an issue queue (integer or memory) and its ALU/AGU pipelines.

---
 rtl/mips_core_pkg.sv | 17 +
 rtl/age_matrix_picker.sv | 28 ++
 rtl/age_ordered_issue_select.sv | 132 +++++++++++++
 tb/tb_age_ordered_issue_select.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared issue-stage definitions: dispatch slot layout and select-policy encodings.
package mips_core_pkg;

  localparam int ISSUE_WIDTH_MAX = 4;

  // Widest entry index a dispatch slot can carry (queues up to 256 entries).
  localparam int SLOT_IDX_W = 8;

  localparam int AGE_ORDER_INDEX  = 0;
  localparam int AGE_ORDER_OLDEST = 1;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_IDX_W-1:0] idx;
  } slot_t;

endpackage

// File: rtl/age_matrix_picker.sv
// One select stage: one-hot of the oldest (or lowest-index) entry in elig.
module age_matrix_picker
  import mips_core_pkg::*;
#(
  parameter int QUEUE_SIZE = 16,
  parameter int AGE_ORDER  = AGE_ORDER_OLDEST
) (
  input  logic [QUEUE_SIZE-1:0]                 elig,
  input  logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0] age,
  output logic [QUEUE_SIZE-1:0]                 grant
);

  logic [QUEUE_SIZE-1:0] oldest;
  logic [QUEUE_SIZE-1:0] lowest;

  // Entry i wins when no other eligible entry j is marked older than it (age[j][i]).
  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_col
    logic [QUEUE_SIZE-1:0] older;
    for (genvar j = 0; j < QUEUE_SIZE; j++) begin : g_row
      assign older[j] = elig[j] & age[j][i];
    end
    assign oldest[i] = elig[i] & ~|older;
  end

  assign lowest = elig & (~elig + QUEUE_SIZE'(1));
  assign grant  = (AGE_ORDER == AGE_ORDER_OLDEST) ? oldest : lowest;

endmodule

// File: rtl/age_ordered_issue_select.sv
// Age-matrix issue select: picks up to ISSUE_WIDTH ready entries per cycle into dispatch slots.
module age_ordered_issue_select
  import mips_core_pkg::*;
#(
  parameter int QUEUE_SIZE  = 16,
  parameter int QUEUE_INDEX = $clog2(QUEUE_SIZE),
  parameter int ISSUE_WIDTH = 2,
  parameter int AGE_ORDER   = AGE_ORDER_OLDEST
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alloc_valid,
  input  logic [QUEUE_INDEX-1:0]           alloc_idx,
  input  logic [QUEUE_SIZE-1:0]            req_vec,
  input  logic                             flush_all,
  input  logic [QUEUE_SIZE-1:0]            flush_mask,
  output logic [QUEUE_SIZE-1:0]            issue_vec,
  output logic [ISSUE_WIDTH-1:0]           out_valid,
  output logic [ISSUE_WIDTH*QUEUE_INDEX-1:0] out_idx,
  input  logic [ISSUE_WIDTH-1:0]           out_ready,
  output logic [QUEUE_INDEX:0]             occupancy
);

  logic [QUEUE_SIZE-1:0]                 live_q;
  logic [QUEUE_SIZE-1:0]                 live_d;
  logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0] age_q;
  logic [QUEUE_SIZE-1:0]                 elig;
  logic [QUEUE_SIZE-1:0]                 stage_mask [ISSUE_WIDTH];
  logic [QUEUE_SIZE-1:0]                 grant      [ISSUE_WIDTH];
  logic [QUEUE_SIZE-1:0]                 port_grant [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0]                avail;
  logic [ISSUE_WIDTH-1:0]                unused_slot_idx;
  slot_t                                 slot_q [ISSUE_WIDTH];
  slot_t                                 slot_d [ISSUE_WIDTH];
  int                                    port_rank;

  // Flushed entries never compete, so a grant and a kill on one entry cannot both happen.
  assign elig  = live_q & req_vec & ~flush_mask & {QUEUE_SIZE{~flush_all}};
  assign avail = ~out_valid | out_ready;

  // Pick k sees the eligible set minus everything picks 0..k-1 already took.
  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_pick
    if (k == 0) begin : g_first
      assign stage_mask[k] = elig;
    end else begin : g_next
      assign stage_mask[k] = stage_mask[k-1] & ~grant[k-1];
    end
    age_matrix_picker #(
      .QUEUE_SIZE(QUEUE_SIZE),
      .AGE_ORDER (AGE_ORDER)
    ) u_picker (
      .elig (stage_mask[k]),
      .age  (age_q),
      .grant(grant[k])
    );
  end

  // The k-th free port (lowest-numbered first) receives pick k.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    port_rank = 0;
    issue_vec = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      port_grant[p] = '0;
      if (avail[p]) begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          if (port_rank == k) port_grant[p] = grant[k];
        end
        port_rank++;
      end
      issue_vec |= port_grant[p];
    end
  end

  always_comb begin
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      slot_d[p] = slot_q[p];
      if (flush_all) begin
        slot_d[p].valid = 1'b0;
      end else if (avail[p]) begin
        slot_d[p].valid = |port_grant[p];
        for (int i = 0; i < QUEUE_SIZE; i++) begin
          if (port_grant[p][i]) slot_d[p].idx = SLOT_IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    live_d = live_q & ~issue_vec & ~flush_mask;
    if (alloc_valid && !flush_mask[alloc_idx]) live_d[alloc_idx] = 1'b1;
    if (flush_all) live_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the age matrix is reset like any other state so a fresh queue starts from a known order.
      live_q    <= '0;
      age_q     <= '0;
      occupancy <= '0;
      for (int p = 0; p < ISSUE_WIDTH; p++) slot_q[p] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      live_q    <= live_d;
      slot_q    <= slot_d;
      // Counting live_d keeps occupancy equal to the tracked set, including alloc/flush collisions.
      occupancy <= (QUEUE_INDEX+1)'($countones(live_d));
      if (alloc_valid && !flush_all) begin
        age_q[alloc_idx] <= '0;
        for (int j = 0; j < QUEUE_SIZE; j++) begin
          if (j != int'(alloc_idx)) age_q[j][alloc_idx] <= live_q[j];
        end
      end
    end
  end

  for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : g_out
    assign out_valid[p]                          = slot_q[p].valid;
    assign out_idx[p*QUEUE_INDEX +: QUEUE_INDEX] = slot_q[p].idx[QUEUE_INDEX-1:0];
    assign unused_slot_idx[p]                    = ^slot_q[p].idx;
  end

  always_ff @(posedge clk) begin
    if (rst_n && alloc_valid && !flush_all) begin
      assert (!live_q[alloc_idx])
        else $error("allocation of already-live entry %0d", alloc_idx);
      assert (occupancy != (QUEUE_INDEX+1)'(QUEUE_SIZE))
        else $error("allocation into a full queue");
    end
  end

endmodule

// File: tb/tb_age_ordered_issue_select.sv
// Bench for age_ordered_issue_select: oldest-first and lowest-index instances against a stamp-based model.
module tb_age_ordered_issue_select;

  localparam int N  = 16;
  localparam int QI = 4;
  localparam int W  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alloc_valid = 1'b0;
  logic [QI-1:0]   alloc_idx = '0;
  logic [N-1:0]    req_vec = '0;
  logic            flush_all = 1'b0;
  logic [N-1:0]    flush_mask = '0;
  logic [W-1:0]    out_ready = '0;

  logic [N-1:0]    issue_a, issue_l;
  logic [W-1:0]    ov_a, ov_l;
  logic [W*QI-1:0] oi_a, oi_l;
  logic [QI:0]     occ_a, occ_l;

  // Model: live set, allocation timestamp per entry (smaller = older), slot contents.
  bit [N-1:0] m_live  [2];
  int         m_stamp [2][N];
  bit         m_sv    [2][W];
  int         m_si    [2][W];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  age_ordered_issue_select #(
    .QUEUE_SIZE(N), .QUEUE_INDEX(QI), .ISSUE_WIDTH(W), .AGE_ORDER(1)
  ) dut_age (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .req_vec(req_vec), .flush_all(flush_all), .flush_mask(flush_mask),
    .issue_vec(issue_a), .out_valid(ov_a), .out_idx(oi_a),
    .out_ready(out_ready), .occupancy(occ_a)
  );

  age_ordered_issue_select #(
    .QUEUE_SIZE(N), .QUEUE_INDEX(QI), .ISSUE_WIDTH(W), .AGE_ORDER(0)
  ) dut_lgc (
    .clk(clk), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
    .req_vec(req_vec), .flush_all(flush_all), .flush_mask(flush_mask),
    .issue_vec(issue_l), .out_valid(ov_l), .out_idx(oi_l),
    .out_ready(out_ready), .occupancy(occ_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_live[m] = '0;
      for (int i = 0; i < N; i++) m_stamp[m][i] = 0;
      for (int p = 0; p < W; p++) begin
        m_sv[m][p] = 1'b0;
        m_si[m][p] = 0;
      end
    end
  endtask

  // Compares one instance against the model for the current cycle, then advances the model.
  task automatic model_step(input int m, input logic [N-1:0] act_issue, input logic [W-1:0] act_v,
                            input logic [W*QI-1:0] act_idx, input logic [QI:0] act_occ);
    bit [N-1:0] elig;
    bit [N-1:0] picked;
    int         ports [W];
    int         n_av;
    int         best;
    bit         nv [W];
    int         ni [W];
    string      tag;
    tag = (m == 0) ? "age" : "lgc";
    check({tag, ".occupancy"}, 32'(act_occ), 32'($countones(m_live[m])));
    for (int p = 0; p < W; p++) begin
      check($sformatf("%s.out_valid[%0d]", tag, p), 32'(act_v[p]), 32'(m_sv[m][p]));
      if (m_sv[m][p])
        check($sformatf("%s.out_idx[%0d]", tag, p), 32'(act_idx[p*QI +: QI]), 32'(m_si[m][p]));
    end
    for (int i = 0; i < N; i++)
      elig[i] = m_live[m][i] && req_vec[i] && !flush_mask[i] && !flush_all;
    n_av = 0;
    for (int p = 0; p < W; p++) begin
      ports[p] = 0;
      nv[p] = m_sv[m][p];
      ni[p] = m_si[m][p];
    end
    for (int p = 0; p < W; p++) begin
      if (!m_sv[m][p] || out_ready[p]) begin
        ports[n_av] = p;
        n_av++;
      end
    end
    picked = '0;
    for (int k = 0; k < n_av; k++) begin
      best = -1;
      for (int i = 0; i < N; i++) begin
        if (elig[i] && !picked[i]) begin
          if (best < 0 || (m == 0 && m_stamp[m][i] < m_stamp[m][best])) best = i;
        end
      end
      nv[ports[k]] = (best >= 0);
      if (best >= 0) begin
        picked[best] = 1'b1;
        ni[ports[k]] = best;
      end
    end
    check({tag, ".issue_vec"}, 32'(act_issue), 32'(picked));
    if (flush_all) begin
      m_live[m] = '0;
      for (int p = 0; p < W; p++) m_sv[m][p] = 1'b0;
    end else begin
      for (int p = 0; p < W; p++) begin
        m_sv[m][p] = nv[p];
        m_si[m][p] = ni[p];
      end
      m_live[m] = m_live[m] & ~picked & ~flush_mask;
      if (alloc_valid && !flush_mask[alloc_idx]) begin
        m_live[m][alloc_idx] = 1'b1;
        m_stamp[m][alloc_idx] = cyc;
      end
    end
  endtask

  // Per-cycle compare at the falling edge; returns 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      model_step(0, issue_a, ov_a, oi_a, occ_a);
      model_step(1, issue_l, ov_l, oi_l, occ_l);
    end else begin
      model_reset();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alloc_valid = 1'b0;
    req_vec     = '0;
    flush_mask  = '0;
    flush_all   = 1'b0;
    out_ready   = '1;
  endtask

  task automatic do_alloc(input int idx);
    alloc_valid = 1'b1;
    alloc_idx   = QI'(idx);
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    set_idle();
    #12 rst_n = 1'b1;
    tick();
    check("lit.reset_out_valid", 32'(ov_a), 32'd0);
    check("lit.reset_occupancy", 32'(occ_a), 32'd0);

    // Oldest-first vs lowest-index with entries allocated 5, 2, 9.
    do_alloc(5); do_alloc(2); do_alloc(9);
    req_vec = 16'h0224;
    #3;
    check("lit.age_pick_set", 32'(issue_a), 32'h0024);
    check("lit.lgc_pick_set", 32'(issue_l), 32'h0024);
    tick();
    check("lit.age_port0", 32'(oi_a[3:0]), 32'd5);
    check("lit.age_port1", 32'(oi_a[7:4]), 32'd2);
    check("lit.lgc_port0", 32'(oi_l[3:0]), 32'd2);
    check("lit.lgc_port1", 32'(oi_l[7:4]), 32'd5);
    #3;
    check("lit.age_third", 32'(issue_a), 32'h0200);
    tick();
    check("lit.age_third_valid", 32'(ov_a), 32'b01);
    check("lit.age_third_idx", 32'(oi_a[3:0]), 32'd9);
    set_idle(); tick();

    // Backpressure on port 0 while port 1 keeps draining.
    do_alloc(5); do_alloc(10); do_alloc(11); do_alloc(12); do_alloc(13);
    req_vec = 16'h0020; out_ready = 2'b00;
    tick();
    check("lit.bp_load_idx", 32'(oi_a[3:0]), 32'd5);
    out_ready = 2'b10; req_vec = 16'h1C00;
    for (int c = 0; c < 3; c++) begin
      #3;
      check("lit.bp_issue", 32'(issue_a), 32'(1 << (10 + c)));
      tick();
      check("lit.bp_valid", 32'(ov_a), 32'b11);
      check("lit.bp_hold_idx", 32'(oi_a[3:0]), 32'd5);
      check("lit.bp_port1_idx", 32'(oi_a[7:4]), 32'(10 + c));
    end
    out_ready = 2'b11; req_vec = 16'h2000;
    #3;
    check("lit.bp_release_issue", 32'(issue_a), 32'h2000);
    tick();
    check("lit.bp_release_valid", 32'(ov_a), 32'b01);
    check("lit.bp_release_idx", 32'(oi_a[3:0]), 32'd13);
    set_idle(); tick();

    // Selective flush racing grants.
    do_alloc(1); do_alloc(3); do_alloc(7);
    check("lit.fm_occ_before", 32'(occ_a), 32'd3);
    req_vec = 16'h008A; flush_mask = 16'h0008;
    #3;
    check("lit.fm_issue", 32'(issue_a), 32'h0082);
    tick();
    check("lit.fm_occ_after", 32'(occ_a), 32'd0);
    check("lit.fm_port0", 32'(oi_a[3:0]), 32'd1);
    check("lit.fm_port1", 32'(oi_a[7:4]), 32'd7);
    set_idle(); tick();

    // Full flush with valid slots and a simultaneous allocation.
    do_alloc(4); do_alloc(6); do_alloc(9);
    req_vec = 16'h0050; out_ready = 2'b00;
    tick();
    check("lit.fa_slots_full", 32'(ov_a), 32'b11);
    flush_all = 1'b1; alloc_valid = 1'b1; alloc_idx = 4'd8; req_vec = 16'h0300;
    #3;
    check("lit.fa_issue", 32'(issue_a), 32'h0000);
    tick();
    check("lit.fa_out_valid", 32'(ov_a), 32'b00);
    check("lit.fa_occupancy", 32'(occ_a), 32'd0);
    flush_all = 1'b0; alloc_valid = 1'b0; out_ready = 2'b11;
    #3;
    check("lit.fa_alloc_dropped", 32'(issue_a), 32'h0000);
    tick();
    set_idle(); tick();

    // Asynchronous reset between edges with both slots occupied.
    do_alloc(2); do_alloc(3); do_alloc(11);
    req_vec = 16'h000C; out_ready = 2'b00;
    tick();
    check("lit.ar_slots_full", 32'(ov_a), 32'b11);
    check("lit.ar_occ_before", 32'(occ_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("lit.ar_out_valid", 32'(ov_a), 32'b00);
    check("lit.ar_out_idx", 32'(oi_a), 32'd0);
    check("lit.ar_occupancy", 32'(occ_a), 32'd0);
    check("lit.ar_lgc_out_valid", 32'(ov_l), 32'b00);
    set_idle();
    model_reset();
    tick();
    #1 rst_n = 1'b1;
    tick();

    // Randomised traffic: legal allocations, random readiness, flushes and backpressure.
    for (int c = 0; c < 4000; c++) begin
      bit [N-1:0] free;
      int         nth;
      free = ~(m_live[0] | m_live[1]);
      alloc_valid = 1'b0;
      if (free != '0 && $urandom_range(3) != 0) begin
        nth = $urandom_range($countones(free) - 1);
        for (int i = 0; i < N; i++) begin
          if (free[i]) begin
            if (nth == 0) begin
              alloc_valid = 1'b1;
              alloc_idx   = QI'(i);
            end
            nth--;
          end
        end
      end
      req_vec    = N'($urandom | $urandom);
      flush_mask = ($urandom_range(9) == 0) ? N'($urandom & $urandom & $urandom) : '0;
      flush_all  = ($urandom_range(59) == 0);
      out_ready  = W'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
